dlfloat_operand_loader: RTL



---
 rtl/dlfloat_pkg.sv | 24 ++
 rtl/dlf_sync_fifo.sv | 62 ++++++
 rtl/dlfloat_operand_loader.sv | 84 ++++++++
 3 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 types and constants for the MAC operand path.
// Word layout: sign[15], exp[14:9], mant[8:0].
package dlfloat_pkg;

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned MANT_W = 9;

  typedef logic [15:0] dlfloat16_t;

  localparam dlfloat16_t DLF_ZERO     = 16'h0000;
  localparam dlfloat16_t DLF_NEG_ZERO = 16'h8000;

  typedef struct packed {
    dlfloat16_t a;
    dlfloat16_t b;
    logic       last;
  } dlf_pair_t;

  // Only -0 is rewritten; subnormal-looking encodings pass through untouched.
  function automatic dlfloat16_t dlf_canon(input dlfloat16_t x);
    return (x == DLF_NEG_ZERO) ? DLF_ZERO : x;
  endfunction

endpackage

// File: rtl/dlf_sync_fifo.sv
// Synchronous circular-buffer FIFO of operand pairs; head entry is always visible on rdata.
module dlf_sync_fifo
  import dlfloat_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  dlf_pair_t                wdata,
  input  logic                     pop,
  output dlf_pair_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  dlf_pair_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/dlfloat_operand_loader.sv
// Pairs a DLFloat16 word stream into (a, b) operands for dlfloat_mac,
// canonicalising -0 and buffering completed pairs in a small FIFO.
module dlfloat_operand_loader
  import dlfloat_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  output logic [15:0]            out_a,
  output logic [15:0]            out_b,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   pair_error
);

  typedef enum logic {PhA, PhB} phase_e;

  phase_e     phase_q;
  dlfloat16_t a_hold_q;
  logic       pair_error_q;
  logic       in_fire, push, pop, fifo_full, fifo_empty;
  dlf_pair_t  push_pair, head_pair;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (phase_q == PhA) || !fifo_full;
  assign in_fire   = in_valid & in_ready;
  assign push      = in_fire & (phase_q == PhB);
  assign pop       = out_valid & out_ready;

  assign push_pair = '{a: dlf_canon(a_hold_q), b: dlf_canon(in_data), last: in_last};

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PhA;
      a_hold_q     <= DLF_ZERO;
      pair_error_q <= 1'b0;
    end else begin
      pair_error_q <= 1'b0;
      if (in_fire) begin
        unique case (phase_q)
          PhA: begin
            // A last marker on an a-word cannot close a pair: drop it and flag.
            if (in_last) begin
              pair_error_q <= 1'b1;
            end else begin
              a_hold_q <= in_data;
              phase_q  <= PhB;
            end
          end
          PhB: phase_q <= PhA;
          default: phase_q <= PhA;
        endcase
      end
    end
  end

  dlf_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_pair),
    .pop   (pop),
    .rdata (head_pair),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign out_a      = head_pair.a;
  assign out_b      = head_pair.b;
  assign out_last   = head_pair.last;
  assign out_valid  = !fifo_empty;
  assign pair_error = pair_error_q;

endmodule
